// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: op encoding, bundle size and
// the pending-branch payload carried through the FIFO.
package branch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BUNDLE_BYTES = 8;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b010,
        BR_BGE  = 3'b011,
        BR_BLTU = 3'b100,
        BR_BGEU = 3'b101,
        BR_JAL  = 3'b110,
        BR_JALR = 3'b111
    } br_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        br_op_t          op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pred_pc;
    } br_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Synchronous FIFO of pending branches; clear wins over push and pop on the same edge.
module branch_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  br_entry_t                din,
    input  logic                     pop,
    input  logic                     clear,
    output br_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    br_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves buffered branches in order, reports each outcome to the predictor
// and squashes wrong-path branches after a misprediction.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  br_op_t      in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pred_pc,
    input  logic        cache_stall,
    output logic        branch_signal,
    output logic        real_take_or_not_signal,
    output logic [31:0] feedback_pc,
    output logic [31:0] correct_pc,
    output logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SQ_W  = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    state_t             state_q, state_d;
    logic [SQ_W-1:0]    sq_cnt_q, sq_cnt_d;

    br_entry_t          in_entry;
    br_entry_t          head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_en;
    logic               pop_en;
    logic               flush;
    logic               taken;
    logic [31:0]        target;
    logic               head_mis;

    assign in_entry = '{pc: in_pc, op: in_op, rs1: in_rs1, rs2: in_rs2,
                        imm: in_imm, pred_pc: in_pred_pc};
    assign in_ready = (fifo_count < CNT_W'(DEPTH));
    // Wrong-path inputs during SQUASH are accepted but never buffered.
    assign push_en  = in_valid && !fifo_full && (state_q == ST_RUN);
    assign pop_en   = (state_q == ST_RUN) && !fifo_empty && !cache_stall;
    assign flush    = pop_en && head_mis;

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_en),
        .din   (in_entry),
        .pop   (pop_en),
        .clear (flush),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Condition and next-PC evaluation for the FIFO head.
    always_comb begin
        taken = 1'b0;
        case (head.op)
            BR_BEQ:  taken = (head.rs1 == head.rs2);
            BR_BNE:  taken = (head.rs1 != head.rs2);
            BR_BLT:  taken = ($signed(head.rs1) <  $signed(head.rs2));
            BR_BGE:  taken = ($signed(head.rs1) >= $signed(head.rs2));
            BR_BLTU: taken = (head.rs1 <  head.rs2);
            BR_BGEU: taken = (head.rs1 >= head.rs2);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (head.op == BR_JALR) begin
            target = (head.rs1 + head.imm) & ~32'h1;
        end else if (taken) begin
            target = head.pc + head.imm;
        end else begin
            target = head.pc + 32'(BUNDLE_BYTES);
        end
        head_mis = (target != head.pred_pc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            sq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // The squash window spans SQUASH_CYCLES unstalled cycles after the mispredict edge.
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d  = ST_SQUASH;
                    sq_cnt_d = SQ_W'(SQUASH_CYCLES);
                end
            end
            ST_SQUASH: begin
                if (!cache_stall) begin
                    if (sq_cnt_q <= SQ_W'(1)) begin
                        state_d  = ST_RUN;
                        sq_cnt_d = '0;
                    end else begin
                        sq_cnt_d = sq_cnt_q - SQ_W'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_signal           <= 1'b0;
            real_take_or_not_signal <= 1'b0;
            feedback_pc             <= '0;
            correct_pc              <= '0;
            mispredict              <= 1'b0;
            branch_count            <= '0;
            mispredict_count        <= '0;
        end else begin
            branch_signal <= pop_en;
            mispredict    <= flush;
            if (pop_en) begin
                real_take_or_not_signal <= taken;
                feedback_pc             <= head.pc;
                correct_pc              <= target;
                if (branch_count != 32'hFFFF_FFFF) begin
                    branch_count <= branch_count + 32'd1;
                end
            end
            if (flush && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected resolutions are queued at
// drive time and compared whenever the unit reports a resolution.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    br_op_t      in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pred_pc;
    logic        cache_stall;
    logic        branch_signal;
    logic        real_take_or_not_signal;
    logic [31:0] feedback_pc;
    logic [31:0] correct_pc;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    typedef struct {
        logic        taken;
        logic [31:0] fb_pc;
        logic [31:0] next_pc;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_vec = 0;
    int   n_err = 0;

    branch_resolve_unit #(.DEPTH(4), .SQUASH_CYCLES(2)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_pc                   (in_pc),
        .in_op                   (in_op),
        .in_rs1                  (in_rs1),
        .in_rs2                  (in_rs2),
        .in_imm                  (in_imm),
        .in_pred_pc              (in_pred_pc),
        .cache_stall             (cache_stall),
        .branch_signal           (branch_signal),
        .real_take_or_not_signal (real_take_or_not_signal),
        .feedback_pc             (feedback_pc),
        .correct_pc              (correct_pc),
        .mispredict              (mispredict),
        .branch_count            (branch_count),
        .mispredict_count        (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input br_op_t op, input logic [31:0] pc, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm,
                                   input logic [31:0] pred);
        exp_t        r;
        logic [31:0] sum;
        logic        lt_s;
        lt_s = (a[31] != b[31]) ? a[31] : (a < b);
        case (op)
            BR_BEQ:  r.taken = (a == b);
            BR_BNE:  r.taken = (a != b);
            BR_BLT:  r.taken = lt_s;
            BR_BGE:  r.taken = !lt_s;
            BR_BLTU: r.taken = (a < b);
            BR_BGEU: r.taken = !(a < b);
            default: r.taken = 1'b1;
        endcase
        if (op == BR_JALR) begin
            sum       = a + imm;
            r.next_pc = {sum[31:1], 1'b0};
        end else begin
            r.next_pc = r.taken ? (pc + imm) : (pc + 32'd8);
        end
        r.fb_pc = pc;
        r.mis   = (r.next_pc != pred);
        return r;
    endfunction

    // Drive one op from the next falling edge; expected result is queued when it should resolve.
    task automatic send(input br_op_t op, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pred,
                        input bit keep);
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = op;
        in_pc      = pc;
        in_rs1     = a;
        in_rs2     = b;
        in_imm     = imm;
        in_pred_pc = pred;
        if (keep) begin
            check("accept_ready", in_ready, 1);
            sb_q.push_back(model(op, pc, a, b, imm, pred));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("mis_without_bs", 32'(mispredict && !branch_signal), 0);
            if (branch_signal) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_bs", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("taken", real_take_or_not_signal, sb_e.taken);
                    check("feedback_pc", feedback_pc, sb_e.fb_pc);
                    check("correct_pc", correct_pc, sb_e.next_pc);
                    check("mispredict", mispredict, sb_e.mis);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_op       = BR_BEQ;
        in_pc       = '0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_imm      = '0;
        in_pred_pc  = '0;
        cache_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bs", branch_signal, 0);
        check("rst_taken", real_take_or_not_signal, 0);
        check("rst_fbpc", feedback_pc, 0);
        check("rst_cpc", correct_pc, 0);
        check("rst_mis", mispredict, 0);
        check("rst_bcnt", branch_count, 0);
        check("rst_mcnt", mispredict_count, 0);
        check("rst_ready", in_ready, 1);
        reset = 1'b0;

        // Single BEQ: resolves one edge after acceptance
        send(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h40, 32'h140, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_early", branch_signal, 0);
        @(negedge clk);
        check("lat_bs", branch_signal, 1);
        check("lat_cpc", correct_pc, 32'h140);
        @(negedge clk);
        check("pulse_end", branch_signal, 0);

        // Mispredicting BNE with two younger branches queued behind it
        cache_stall = 1'b1;
        send(BR_BNE, 32'h200, 32'd7, 32'd7, 32'h40, 32'h240, 1'b1);
        send(BR_BEQ, 32'h208, 32'd1, 32'd1, 32'h10, 32'h218, 1'b0);
        send(BR_JAL, 32'h210, 32'd0, 32'd0, 32'h30, 32'h240, 1'b0);
        @(negedge clk);
        in_valid    = 1'b0;
        cache_stall = 1'b0;
        @(negedge clk);
        check("flush_mis", mispredict, 1);
        check("flush_cpc", correct_pc, 32'h208);
        in_valid = 1'b1;
        in_op    = BR_JAL;
        in_pc    = 32'h900;
        in_imm   = 32'h8;
        check("squash_ready", in_ready, 1);
        @(negedge clk);
        in_pc = 32'h910;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_bcnt", branch_count, 2);
        check("flush_mcnt", mispredict_count, 1);

        // Post-squash op must be accepted again
        send(BR_JAL, 32'h500, 32'd0, 32'd0, 32'h20, 32'h520, 1'b1);

        // Signed vs unsigned compares on the same operands
        send(BR_BLT,  32'h300, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h320, 1'b1);
        send(BR_BLTU, 32'h308, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h310, 1'b1);
        send(BR_BGE,  32'h310, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h318, 1'b1);
        send(BR_BGEU, 32'h318, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h338, 1'b1);
        send(BR_JALR, 32'h400, 32'h1001, 32'd0, 32'h10, 32'h1010, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("seq_bcnt", branch_count, 8);
        check("seq_cpc", correct_pc, 32'h1010);

        // Fill the buffer under stall, then drain back-to-back
        cache_stall = 1'b1;
        send(BR_BEQ, 32'h600, 32'd1, 32'd2, 32'h10, 32'h608, 1'b1);
        send(BR_BNE, 32'h608, 32'd1, 32'd2, 32'h10, 32'h618, 1'b1);
        send(BR_BGE, 32'h610, 32'd3, 32'd3, 32'h10, 32'h620, 1'b1);
        send(BR_JAL, 32'h618, 32'd0, 32'd0, 32'h100, 32'h718, 1'b1);
        @(negedge clk);
        in_pc = 32'h620;
        check("full_ready", in_ready, 0);
        in_valid    = 1'b0;
        cache_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_bs", branch_signal, 1);
        end
        @(negedge clk);
        check("drain_end", branch_signal, 0);

        // Reset while in SQUASH with a stall holding the window open
        cache_stall = 1'b1;
        send(BR_BEQ, 32'h700, 32'd4, 32'd4, 32'h40, 32'h708, 1'b1);
        send(BR_BNE, 32'h708, 32'd4, 32'd5, 32'h40, 32'h748, 1'b0);
        send(BR_BEQ, 32'h710, 32'd4, 32'd5, 32'h40, 32'h718, 1'b0);
        @(negedge clk);
        in_valid    = 1'b0;
        cache_stall = 1'b0;
        @(negedge clk);
        cache_stall = 1'b1;
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("mrst_bs", branch_signal, 0);
        check("mrst_cpc", correct_pc, 0);
        check("mrst_bcnt", branch_count, 0);
        check("mrst_mcnt", mispredict_count, 0);
        reset       = 1'b0;
        cache_stall = 1'b0;
        @(negedge clk);
        check("mrst_ready", in_ready, 1);

        // Back in RUN after reset
        send(BR_BNE, 32'h800, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h7F8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_bcnt", branch_count, 1);
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
